// File: rtl/fetch_if.sv
// fetch_if: control, program-memory and IF/ID bundle for the fetch stage
interface fetch_if #(parameter int DATA_WIDTH = 32);
  logic stall;
  logic flush;
  logic branch_taken;
  logic [DATA_WIDTH-1:0] branch_target;
  logic jump;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] instruction_in;
  logic [DATA_WIDTH-1:0] pc_out;
  logic [DATA_WIDTH-1:0] if_id_instruction;
  logic [DATA_WIDTH-1:0] if_id_pc_plus4;
  logic if_id_valid;
  logic misalign_err;
  logic range_err;
  logic [DATA_WIDTH-1:0] fetch_count;
  modport master (
    output stall, flush, branch_taken, branch_target, jump, jump_target, instruction_in,
    input pc_out, if_id_instruction, if_id_pc_plus4, if_id_valid, misalign_err, range_err, fetch_count
  );
  modport slave (
    input stall, flush, branch_taken, branch_target, jump, jump_target, instruction_in,
    output pc_out, if_id_instruction, if_id_pc_plus4, if_id_valid, misalign_err, range_err, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register with branch/jump redirect, IF/ID pipeline register and sticky error flags
module fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  fetch_if.slave bus
);
  logic redirect, out_of_range, valid, mis, rng;
  logic [DATA_WIDTH-1:0] target, pc, pc_plus4, ins, pp4, cnt;
  assign redirect = bus.branch_taken | bus.jump;
  assign target = bus.branch_taken ? bus.branch_target : bus.jump_target;
  assign pc_plus4 = pc + DATA_WIDTH'(4);
  assign out_of_range = (pc >> 2) >= DATA_WIDTH'(MEMORY_DEPTH);
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      ins <= '0;
      pp4 <= '0;
      valid <= 1'b0;
      cnt <= '0;
      mis <= 1'b0;
      rng <= 1'b0;
    end else begin
      pc <= redirect ? {target[DATA_WIDTH-1:2], 2'b00} : bus.stall ? pc : pc_plus4;
      mis <= mis | (redirect & |target[1:0]);
      // a redirect discards the wrong-path word currently on instruction_in
      if (bus.flush | redirect) begin
        ins <= '0;
        pp4 <= '0;
        valid <= 1'b0;
      end else if (!bus.stall) begin
        ins <= bus.instruction_in;
        pp4 <= pc_plus4;
        valid <= 1'b1;
        cnt <= &cnt ? cnt : cnt + DATA_WIDTH'(1);
        rng <= rng | out_of_range;
      end
    end
  end
  assign bus.pc_out = pc;
  assign bus.if_id_instruction = ins;
  assign bus.if_id_pc_plus4 = pp4;
  assign bus.if_id_valid = valid;
  assign bus.fetch_count = cnt;
  assign bus.misalign_err = mis;
  assign bus.range_err = rng;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus pushes expected post-edge state; a monitor pops and compares after each edge
module tb_fetch_stage;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pp4;
    logic valid;
    logic mis;
    logic rng;
    logic [31:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  fetch_if #(.DATA_WIDTH(32)) bus();
  fetch_stage #(.DATA_WIDTH(32), .MEMORY_DEPTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // program memory: word at address a is {a[15:0], 16'h1234}
  assign bus.instruction_in = {bus.pc_out[15:0], 16'h1234};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_out", bus.pc_out, e.pc);
      chk("if_id_instruction", bus.if_id_instruction, e.ins);
      chk("if_id_pc_plus4", bus.if_id_pc_plus4, e.pp4);
      chk("if_id_valid", 32'(bus.if_id_valid), 32'(e.valid));
      chk("misalign_err", 32'(bus.misalign_err), 32'(e.mis));
      chk("range_err", 32'(bus.range_err), 32'(e.rng));
      chk("fetch_count", bus.fetch_count, e.cnt);
    end
  end
  task automatic drive(input logic r, input logic s, input logic f, input logic b,
                       input logic [31:0] bt, input logic j, input logic [31:0] jt);
    @(negedge clk);
    reset = r;
    bus.stall = s;
    bus.flush = f;
    bus.branch_taken = b;
    bus.branch_target = bt;
    bus.jump = j;
    bus.jump_target = jt;
  endtask
  task automatic expect_st(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] pp4,
                           input logic v, input logic me, input logic re, input logic [31:0] cnt);
    exp_t e;
    e.pc = pc; e.ins = ins; e.pp4 = pp4; e.valid = v; e.mis = me; e.rng = re; e.cnt = cnt;
    q.push_back(e);
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask
  initial begin
    reset = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.jump = 0;
    bus.branch_target = '0; bus.jump_target = '0;
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0); expect_st(32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    idle(); expect_st(32'h4, 32'h0000_1234, 32'h4, 1, 0, 0, 1);
    idle(); expect_st(32'h8, 32'h0004_1234, 32'h8, 1, 0, 0, 2);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 32'h0, 0, 32'h0); expect_st(32'h8, 32'h0004_1234, 32'h8, 1, 0, 0, 2);
    end
    idle(); expect_st(32'hC, 32'h0008_1234, 32'hC, 1, 0, 0, 3);
    drive(0, 1, 0, 1, 32'h40, 1, 32'h80); expect_st(32'h40, 32'h0, 32'h0, 0, 0, 0, 3);
    idle(); expect_st(32'h44, 32'h0040_1234, 32'h44, 1, 0, 0, 4);
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0); expect_st(32'h48, 32'h0, 32'h0, 0, 0, 0, 4);
    drive(0, 1, 1, 0, 32'h0, 0, 32'h0); expect_st(32'h48, 32'h0, 32'h0, 0, 0, 0, 4);
    idle(); expect_st(32'h4C, 32'h0048_1234, 32'h4C, 1, 0, 0, 5);
    drive(0, 0, 0, 0, 32'h0, 1, 32'h23); expect_st(32'h20, 32'h0, 32'h0, 0, 1, 0, 5);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      a = 32'h20 + 32'(4 * i);
      idle(); expect_st(a + 4, {a[15:0], 16'h1234}, a + 4, 1, 1, 0, 32'(6 + i));
    end
    drive(0, 0, 0, 1, 32'h7C, 0, 32'h0); expect_st(32'h7C, 32'h0, 32'h0, 0, 1, 0, 15);
    idle(); expect_st(32'h80, 32'h007C_1234, 32'h80, 1, 1, 0, 16);
    idle(); expect_st(32'h84, 32'h0080_1234, 32'h84, 1, 1, 1, 17);
    drive(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC); expect_st(32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1, 1, 17);
    idle(); expect_st(32'h0, 32'hFFFC_1234, 32'h0, 1, 1, 1, 18);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0); expect_st(32'h0, 32'hFFFC_1234, 32'h0, 1, 1, 1, 18);
    drive(1, 1, 0, 1, 32'h40, 0, 32'h0); expect_st(32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    idle(); expect_st(32'h4, 32'h0000_1234, 32'h4, 1, 0, 0, 1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
